// File: rtl/c1_bus_master_pkg.sv
// Shared C1 bus definitions: default geometry, command codes, master FSM states
// and command classification helpers.
package c1_pkg;

    localparam int C1_MEM_ADDR_SIZE     = 19;
    localparam int C1_BUS_SIZE          = 16;
    localparam int C1_CACHE_OFFSET_SIZE = 4;
    localparam int C1_TIMEOUT           = 64;

    localparam logic [2:0] C1_NOP          = 3'd0;
    localparam logic [2:0] C1_READ8        = 3'd1;
    localparam logic [2:0] C1_READ16       = 3'd2;
    localparam logic [2:0] C1_READ32       = 3'd3;
    localparam logic [2:0] C1_INV_LINE     = 3'd4;
    localparam logic [2:0] C1_WRITE8       = 3'd5;
    localparam logic [2:0] C1_WRITE16      = 3'd6;
    localparam logic [2:0] C1_WRITE32_RESP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD1  = 3'd1,
        S_CMD2  = 3'd2,
        S_TURN  = 3'd3,
        S_WAIT  = 3'd4,
        S_RESP2 = 3'd5,
        S_DONE  = 3'd6
    } c1m_state_t;

    function automatic logic is_read(input logic [2:0] cmd);
        return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
    endfunction

    function automatic logic is_write(input logic [2:0] cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32_RESP);
    endfunction

    // Code 7 is the response/WRITE32 code and is never accepted as a request.
    function automatic logic is_legal(input logic [2:0] cmd);
        return is_read(cmd) || (cmd == C1_INV_LINE) ||
               (is_write(cmd) && (cmd != C1_WRITE32_RESP));
    endfunction

endpackage

// File: rtl/c1_bus_master_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last accepted port.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_r;

    // Grant the lone requester, or the port not granted last on a tie.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last_r ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Last-granted pointer; reset value makes port 0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (accept) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/c1_bus_master.sv
// C1 bus master: arbitrates two requesters and sequences the command, offset,
// turnaround and response phases of the shared C1 bus.
module c1_bus_master
    import c1_pkg::*;
#(
    parameter int MEM_ADDR_SIZE     = C1_MEM_ADDR_SIZE,
    parameter int BUS_SIZE          = C1_BUS_SIZE,
    parameter int CACHE_OFFSET_SIZE = C1_CACHE_OFFSET_SIZE,
    parameter int TIMEOUT           = C1_TIMEOUT
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [1:0]                               req_valid,
    output logic [1:0]                               req_ready,
    input  logic [1:0][2:0]                          req_cmd,
    input  logic [1:0][MEM_ADDR_SIZE-1:0]            req_addr,
    input  logic [1:0][2*BUS_SIZE-1:0]               req_wdata,
    output logic [1:0]                               rsp_valid,
    output logic [2*BUS_SIZE-1:0]                    rsp_data,
    output logic                                     rsp_err,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                      data,
    inout  wire  [2:0]                               command
);

    localparam int ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int CNT_W  = $clog2(TIMEOUT);

    c1m_state_t                 state_r, state_nxt_s;
    logic [1:0]                 gnt_s;
    logic                       sel_s, accept_s;
    logic [2:0]                 sel_cmd_s;
    logic [MEM_ADDR_SIZE-1:0]   sel_addr_s;
    logic [2*BUS_SIZE-1:0]      sel_wdata_s;

    logic [2:0]                 cmd_r;
    logic [CACHE_OFFSET_SIZE-1:0] addr_off_r;
    logic [2*BUS_SIZE-1:0]      wdata_r;
    logic                       port_r;
    logic [CNT_W-1:0]           cnt_r, cnt_nxt_s;
    logic                       cmd_oe_r, cmd_oe_nxt_s;
    logic                       data_oe_r, data_oe_nxt_s;
    logic [BUS_SIZE-1:0]        data_drv_r, data_drv_nxt_s;
    logic [ADDR_W-1:0]          address_r, address_nxt_s;
    logic [1:0]                 rsp_valid_r, rsp_valid_nxt_s;
    logic [2*BUS_SIZE-1:0]      rsp_data_r, rsp_data_nxt_s;
    logic                       rsp_err_r, rsp_err_nxt_s;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (accept_s),
        .gnt    (gnt_s)
    );

    assign sel_s       = gnt_s[1];
    assign sel_cmd_s   = req_cmd[sel_s];
    assign sel_addr_s  = req_addr[sel_s];
    assign sel_wdata_s = req_wdata[sel_s];

    assign req_ready = (state_r == S_IDLE) ? gnt_s : 2'b00;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;
    assign address   = address_r;
    assign command   = cmd_oe_r  ? cmd_r      : 3'bzzz;
    assign data      = data_oe_r ? data_drv_r : {BUS_SIZE{1'bz}};

    // Next state plus the bus/response values to register for that state.
    always_comb begin
        state_nxt_s     = state_r;
        accept_s        = 1'b0;
        cnt_nxt_s       = cnt_r;
        cmd_oe_nxt_s    = 1'b0;
        data_oe_nxt_s   = 1'b0;
        data_drv_nxt_s  = data_drv_r;
        address_nxt_s   = {ADDR_W{1'b0}};
        rsp_valid_nxt_s = 2'b00;
        rsp_data_nxt_s  = rsp_data_r;
        rsp_err_nxt_s   = rsp_err_r;
        case (state_r)
            S_IDLE: begin
                if (|req_valid) begin
                    accept_s       = 1'b1;
                    rsp_data_nxt_s = {(2*BUS_SIZE){1'b0}};
                    rsp_err_nxt_s  = 1'b0;
                    if (is_legal(sel_cmd_s)) begin
                        state_nxt_s    = S_CMD1;
                        cmd_oe_nxt_s   = 1'b1;
                        address_nxt_s  = sel_addr_s[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
                        data_oe_nxt_s  = is_write(sel_cmd_s);
                        data_drv_nxt_s = sel_wdata_s[BUS_SIZE-1:0];
                    end else begin
                        state_nxt_s     = S_DONE;
                        rsp_err_nxt_s   = 1'b1;
                        rsp_valid_nxt_s = gnt_s;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CMD1: begin
                state_nxt_s   = S_CMD2;
                cmd_oe_nxt_s  = 1'b1;
                address_nxt_s = {{(ADDR_W-CACHE_OFFSET_SIZE){1'b0}}, addr_off_r};
                data_oe_nxt_s = is_write(cmd_r);
                if (cmd_r == C1_WRITE32_RESP) begin
                    data_drv_nxt_s = wdata_r[2*BUS_SIZE-1:BUS_SIZE];
                end else begin
                    data_drv_nxt_s = wdata_r[BUS_SIZE-1:0];
                end
            end
            S_CMD2: begin
                state_nxt_s   = S_TURN;
                data_oe_nxt_s = is_write(cmd_r);
            end
            S_TURN: begin
                state_nxt_s   = S_WAIT;
                cnt_nxt_s     = {CNT_W{1'b0}};
                data_oe_nxt_s = is_write(cmd_r);
            end
            S_WAIT: begin
                // X/Z on the command bus compares false and counts as no response.
                if (command == C1_WRITE32_RESP) begin
                    case (cmd_r)
                        C1_READ8: begin
                            state_nxt_s     = S_DONE;
                            rsp_valid_nxt_s = {port_r, ~port_r};
                            rsp_data_nxt_s  = {{(2*BUS_SIZE-8){1'b0}}, data[7:0]};
                        end
                        C1_READ16: begin
                            state_nxt_s     = S_DONE;
                            rsp_valid_nxt_s = {port_r, ~port_r};
                            rsp_data_nxt_s  = {{BUS_SIZE{1'b0}}, data};
                        end
                        C1_READ32: begin
                            state_nxt_s    = S_RESP2;
                            rsp_data_nxt_s = {{BUS_SIZE{1'b0}}, data};
                        end
                        default: begin
                            state_nxt_s     = S_DONE;
                            rsp_valid_nxt_s = {port_r, ~port_r};
                        end
                    endcase
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt_s     = S_DONE;
                    rsp_valid_nxt_s = {port_r, ~port_r};
                    rsp_err_nxt_s   = 1'b1;
                    rsp_data_nxt_s  = {(2*BUS_SIZE){1'b0}};
                end else begin
                    cnt_nxt_s     = cnt_r + CNT_W'(1);
                    data_oe_nxt_s = is_write(cmd_r);
                end
            end
            S_RESP2: begin
                state_nxt_s     = S_DONE;
                rsp_valid_nxt_s = {port_r, ~port_r};
                rsp_data_nxt_s  = {data, rsp_data_r[BUS_SIZE-1:0]};
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latched transaction plus registered bus enables and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r       <= C1_NOP;
            addr_off_r  <= {CACHE_OFFSET_SIZE{1'b0}};
            wdata_r     <= {(2*BUS_SIZE){1'b0}};
            port_r      <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            cmd_oe_r    <= 1'b0;
            data_oe_r   <= 1'b0;
            data_drv_r  <= {BUS_SIZE{1'b0}};
            address_r   <= {ADDR_W{1'b0}};
            rsp_valid_r <= 2'b00;
            rsp_data_r  <= {(2*BUS_SIZE){1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                cmd_r      <= sel_cmd_s;
                addr_off_r <= sel_addr_s[CACHE_OFFSET_SIZE-1:0];
                wdata_r    <= sel_wdata_s;
                port_r     <= sel_s;
            end else begin
                cmd_r      <= cmd_r;
                addr_off_r <= addr_off_r;
                wdata_r    <= wdata_r;
                port_r     <= port_r;
            end
            cnt_r       <= cnt_nxt_s;
            cmd_oe_r    <= cmd_oe_nxt_s;
            data_oe_r   <= data_oe_nxt_s;
            data_drv_r  <= data_drv_nxt_s;
            address_r   <= address_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
        end
    end

endmodule
